// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the long-latency queue entry type and the default
// queue depth for the writeback arbiter.
package wb_pkg;

  localparam int XLEN          = 32;
  localparam int REG_AW        = 5;
  localparam int QDEPTH_DEFAULT = 4;

  // One buffered long-latency result: destination register plus data.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // One-hot decode of a register index, with x0 never marked.
  function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [XLEN-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous circular FIFO of wb_entry_t. Pointers carry one extra
// wrap bit so that full and empty are distinguished by the pointer difference.
// Head entry is presented combinationally on dout.
import wb_pkg::*;

module wb_fifo #(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

  wb_entry_t   mem [QDEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rptr[AW-1:0]];
  // A push into a full queue is refused even if a pop happens alongside it;
  // the producer sees ready from the pre-pop state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges never-stalled pipeline results and queued long-latency
// results onto the single register-file write port, and keeps a per-register
// busy scoreboard for issue logic.
//
// Build option: define WB_BYPASS_EN to let a long-latency result go straight
// to the write port when the queue is empty and no ALU write wins that cycle.
//
// Handshake: lsu_ready depends only on queue state (!full), never on
// lsu_valid; a result transfers on any cycle where lsu_valid && lsu_ready at
// the rising edge of clk.
import wb_pkg::*;

module wb_arbiter #(
  parameter int QDEPTH = QDEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REG_AW-1:0]        lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     iss_valid,
  input  logic [REG_AW-1:0]        iss_rd,
  output logic [XLEN-1:0]          busy,
  output logic                     stall_req,
  output logic [$clog2(QDEPTH):0]  q_count,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_wa,
  output logic [XLEN-1:0]          rf_wd
);

  wb_entry_t       q_din;
  wb_entry_t       q_head;
  logic            q_full;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            lsu_hs;
  logic            alu_win;
  logic            byp;
  logic            wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] clr_mask;
  logic [XLEN-1:0] set_mask;

  assign lsu_ready = !q_full;
  assign stall_req = q_full;
  assign lsu_hs    = lsu_valid && lsu_ready;
  assign alu_win   = alu_valid && (alu_rd != '0);
  assign q_din     = '{rd: lsu_rd, data: lsu_data};

`ifdef WB_BYPASS_EN
  assign byp = lsu_hs && q_empty && !alu_win;
`else
  assign byp = 1'b0;
`endif

  assign q_push = lsu_hs && !byp;
  assign q_pop  = !alu_win && !q_empty;

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Write-port selection in priority order: ALU, queue head, bypassed result.
  // Queue-sourced writes to x0 are consumed without writing.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rf_wa;
    wr_data  = rf_wd;
    clr_mask = '0;
    if (alu_win) begin
      wr_en   = 1'b1;
      wr_addr = alu_rd;
      wr_data = alu_data;
    end else if (q_pop) begin
      wr_en    = (q_head.rd != '0);
      wr_addr  = q_head.rd;
      wr_data  = q_head.data;
      clr_mask = reg_onehot(q_head.rd);
    end else if (byp) begin
      wr_en    = (lsu_rd != '0);
      wr_addr  = lsu_rd;
      wr_data  = lsu_data;
      clr_mask = reg_onehot(lsu_rd);
    end
  end

  // Issue-side scoreboard set; x0 is never marked.
  always_comb begin
    set_mask = '0;
    if (iss_valid) set_mask = reg_onehot(iss_rd);
  end

  // Registered write port and scoreboard; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      busy  <= '0;
    end else begin
      rf_we <= wr_en;
      rf_wa <= wr_addr;
      rf_wd <= wr_data;
      busy  <= ((busy & ~clr_mask) | set_mask) & ~XLEN'(1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic        stall_req;
  logic [2:0]  q_count;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.QDEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .stall_req (stall_req),
    .q_count   (q_count),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (rf_wa !== 5'd0) begin failures++; $display("FAIL reset_rf_wa got=%0d exp=0", rf_wa); end
    checks++; if (rf_wd !== 32'd0) begin failures++; $display("FAIL reset_rf_wd got=%h exp=0", rf_wd); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_lsu_ready got=%0b exp=1", lsu_ready); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%0b exp=1", rf_we); end
    checks++; if (rf_wa !== 5'd5) begin failures++; $display("FAIL alu_wa got=%0d exp=5", rf_wa); end
    checks++; if (rf_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_wd got=%h exp=deadbeef", rf_wd); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL alu_busy got=%h exp=0", busy); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_we_idle got=%0b exp=0", rf_we); end
  endtask

  task automatic test_issue_load();
    iss_valid = 1; iss_rd = 7;
    step();
    idle_inputs();
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL iss_busy_set got=%h exp=00000080", busy); end
    step();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL load_ready got=%0b exp=1", lsu_ready); end
    step();
    idle_inputs();
`ifndef WB_BYPASS_EN
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL load_early_we got=%0b exp=0", rf_we); end
    checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL load_qcount got=%0d exp=1", q_count); end
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL load_busy_hold got=%h exp=00000080", busy); end
    step();
`endif
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h1234)
      begin failures++; $display("FAIL load_write got=%0b/%0d/%h exp=1/7/00001234", rf_we, rf_wa, rf_wd); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL load_busy_clr got=%h exp=0", busy); end
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL load_qcount_end got=%0d exp=0", q_count); end
    step();
  endtask

  task automatic test_contention();
    // Queue x3 while the ALU writes x4, then keep the ALU busy for three cycles.
    iss_valid = 1; iss_rd = 3;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h40;
    step();
    iss_valid = 0; lsu_valid = 0;
    checks++; if (rf_wa !== 5'd4 || rf_wd !== 32'h40) begin failures++; $display("FAIL cont_first got=%0d/%h exp=4/00000040", rf_wa, rf_wd); end
    for (int i = 1; i <= 3; i++) begin
      alu_data = 32'h40 + 32'(i);
      step();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'h40 + 32'(i))
        begin failures++; $display("FAIL cont_alu%0d got=%0b/%0d/%h exp=1/4/%h", i, rf_we, rf_wa, rf_wd, 32'h40 + 32'(i)); end
      checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL cont_hold%0d got=%0d exp=1", i, q_count); end
      checks++; if (busy !== 32'h8) begin failures++; $display("FAIL cont_busy%0d got=%h exp=00000008", i, busy); end
    end
    idle_inputs();
    step();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h33)
      begin failures++; $display("FAIL cont_queued got=%0b/%0d/%h exp=1/3/00000033", rf_we, rf_wa, rf_wd); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL cont_busy_clr got=%h exp=0", busy); end
    step();
  endtask

  task automatic test_full();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(8 + i); lsu_data = 32'h80 + 32'(i * 16);
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%0b exp=1", i, lsu_ready); end
      step();
    end
    checks++; if (q_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", q_count); end
    checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", lsu_ready); end
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL full_stall got=%0b exp=1", stall_req); end
    // Offer x12 during the first pop: ready reflects pre-pop full, so refused.
    alu_valid = 0;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0;
    step();
    lsu_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd8 || rf_wd !== 32'h80)
      begin failures++; $display("FAIL drain0 got=%0b/%0d/%h exp=1/8/00000080", rf_we, rf_wa, rf_wd); end
    checks++; if (q_count !== 3'd3) begin failures++; $display("FAIL drain_count got=%0d exp=3", q_count); end
    checks++; if (lsu_ready !== 1'b1 || stall_req !== 1'b0)
      begin failures++; $display("FAIL drain_ready got=%0b/%0b exp=1/0", lsu_ready, stall_req); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'(8 + i) || rf_wd !== 32'h80 + 32'(i * 16))
        begin failures++; $display("FAIL drain%0d got=%0b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_wa, rf_wd, 8 + i, 32'h80 + 32'(i * 16)); end
    end
    step();
    checks++; if (rf_we !== 1'b0 || q_count !== 3'd0)
      begin failures++; $display("FAIL drain_end got=%0b/%0d exp=0/0", rf_we, q_count); end
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h99;
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_alu got=%0b exp=0", rf_we); end
    // Queue an x0 result behind an ALU write, then pop it under an x0 ALU op.
    alu_rd = 2; alu_data = 32'h22;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
    step();
    lsu_valid = 0;
    alu_rd = 0;
    iss_valid = 1; iss_rd = 0;
    checks++; if (q_count !== 3'd1) begin failures++; $display("FAIL x0_queued got=%0d exp=1", q_count); end
    step();
    idle_inputs();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_pop_we got=%0b exp=0", rf_we); end
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL x0_popped got=%0d exp=0", q_count); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL x0_busy got=%h exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1; iss_rd = 3;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hA0;
    step();
    iss_rd = 7; lsu_rd = 7; lsu_data = 32'hA1;
    step();
    iss_valid = 0; lsu_rd = 9; lsu_data = 32'hA2;
    step();
    lsu_valid = 0;
    checks++; if (q_count !== 3'd3 || busy !== 32'h88)
      begin failures++; $display("FAIL mid_setup got=%0d/%h exp=3/00000088", q_count, busy); end
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    checks++; if (q_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", q_count); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL mid_busy got=%h exp=0", busy); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_we got=%0b exp=0", rf_we); end
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", lsu_ready); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_after_we got=%0b exp=0", rf_we); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu_only();
    test_issue_load();
    test_contention();
    test_full();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the core's register file. It merges two result sources onto the register file's single write port:
- single-cycle ALU/pipeline results, which cannot be stalled;
- long-latency results (load, mul/div) under a ready/valid handshake.

Long-latency results are buffered in a small queue. A destination-register scoreboard tells issue logic which registers still have a write outstanding.

## Interface
- QDEPTH, 4, long-latency result queue depth (power of two, ≥2)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- alu_valid  in  1  pipeline result valid this cycle (never stalled)
- alu_rd  in  5  pipeline destination register
- alu_data  in  32  pipeline result
- lsu_valid  in  1  long-latency result offered
- lsu_ready  out  1  arbiter can accept a long-latency result
- lsu_rd  in  5  long-latency destination register
- lsu_data  in  32  long-latency result
- iss_valid  in  1  a long-latency instruction issued this cycle
- iss_rd  in  5  its destination register
- busy  out  32  scoreboard; bit i = write to xi outstanding; bit 0 always 0
- stall_req  out  1  queue full; pipeline must insert bubbles
- q_count  out  $clog2(QDEPTH)+1  queue occupancy
- rf_we  out  1  register file write enable
- rf_wa  out  5  register file write address
- rf_wd  out  32  register file write data

## Operation
- lsu_ready = !full; lsu_ready is combinational from the queue state only and does not depend on lsu_valid. A handshake (lsu_valid && lsu_ready) pushes {lsu_rd, lsu_data}.
- Arbitration each cycle, in priority order:
  1. If alu_valid && alu_rd != 0: write the ALU result. The queue holds.
  2. Otherwise, if the queue is non-empty: pop the head. Write it if head.rd != 0; if head.rd == 0, drop it with no write.
  3. Otherwise: no write.
- alu_valid with alu_rd == 0 produces no write and does not block a queue pop.
- Push and pop in the same cycle are both legal, including when the queue is full: a pop frees the slot, but lsu_ready still reflects the pre-pop full state.
- Scoreboard:
  - iss_valid && iss_rd != 0 sets busy[iss_rd].
  - A queue-sourced write to register r clears busy[r].
  - If set and clear hit the same register in the same cycle, set wins.
  - ALU writes never touch the scoreboard.
- Ordering: issue logic must not issue an instruction whose rd is busy. Given that rule, an ALU write and a queued write to the same register never coexist, and no further ordering is enforced here.
- stall_req = full. The ALU has priority, so sustained alu_valid starves the queue; stall_req is the upstream's signal to inject bubbles.

## Timing
- Reset values:
  - rf_we = 0, rf_wa = 0, rf_wd = 0
  - busy = 0, q_count = 0, stall_req = 0
  - lsu_ready = 1
  - queue emptied. Reset mid-operation discards all queued results.
- rf_we/rf_wa/rf_wd are registered.
  - ALU result presented in cycle N: rf_we high in cycle N+1.
  - Long-latency result accepted in cycle N: reaches the queue head in N+1; rf_we high in N+2 at the earliest.
- busy clears on the same edge at which the corresponding rf_we rises.
- busy, q_count and stall_req are registered.

## Configuration
- WB_BYPASS_EN defined: if the queue is empty, there is no winning ALU write, and a handshake occurs in cycle N, the result goes straight to rf_* in N+1 and is not pushed. The scoreboard clears on that edge.
- WB_BYPASS_EN undefined: every accepted result goes through the queue, with 2-cycle minimum latency.

## Structure
- Package wb_pkg holds:
  - XLEN = 32, REG_AW = 5;
  - entry type wb_entry_t {rd[4:0], data[31:0]};
  - the default QDEPTH.
- Sub-module wb_fifo is a synchronous circular FIFO:
  - ports push, pop, din, dout, full, empty, count;
  - wrap-around pointers plus an extra occupancy bit.
- wb_arbiter instantiates wb_fifo and holds the arbitration, scoreboard and output registers.

## Test plan
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 1 → rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle 2; busy unchanged.
- Issue then load: iss_rd=7 in cycle 1 → busy[7]=1 in cycle 2. lsu_rd=7, data=0x1234 accepted in cycle 3 → rf write to x7 in cycle 5 (cycle 4 with WB_BYPASS_EN), and busy[7]=0 on that same cycle.
- Contention: queue holds rd=3; alu_valid on rd=4 for 3 consecutive cycles → three x4 writes, then the x3 write in the 4th cycle.
- Full queue: 4 accepts while alu_valid is held → lsu_ready=0 and stall_req=1. Drop alu_valid → one write per cycle, draining in FIFO order; lsu_ready returns to 1 after the first pop.
- x0 handling: alu_rd=0 or lsu_rd=0 → no rf_we; the queue entry is still popped; iss_rd=0 never sets busy.
- Reset mid-operation: rst with 3 entries queued and busy=0x88 → next cycle q_count=0, busy=0, rf_we=0, lsu_ready=1.
